// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding,
// default operand width and the bit-counter width helper.
package shift_add_mult_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_addsub.sv
// WIDTH-bit adder/subtractor slice: S = A + B (M=0) or A + ~B + 1 (M=1),
// Cout is the carry out of the top bit.
module addsub_slice #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    assign w_b_eff = B ^ {WIDTH{M}};
    assign w_sum   = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, M};
    assign S       = w_sum[WIDTH-1:0];
    assign Cout    = w_sum[WIDTH];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// ASM shift-and-add multiplier controller with start/busy/done handshake.
// Define SHIFT_ADD_MULT_SIGNED_EN for radix-2 Booth (two's complement) mode.
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_a, w_a_next;
    logic [WIDTH-1:0]   r_q, w_q_next;
    logic [WIDTH-1:0]   r_b, w_b_next;
    logic               r_c, w_c_next;
    logic [CNT_W-1:0]   r_p, w_p_next;
    logic [2*WIDTH-1:0] r_product, w_product_next;

    logic [WIDTH-1:0]   w_s;
    logic               w_cout;
    logic               w_m;
    logic               w_do_add;
    logic               w_add_sign;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    logic r_qm1, w_qm1_next;

    assign w_m      = r_q[0] & ~r_qm1;
    assign w_do_add = r_q[0] ^ r_qm1;
    // True sign of the (WIDTH+1)-bit sum, so A-B with B = most-negative
    // value still shifts in the right sign bit; C carries it into SHIFT.
    assign w_add_sign = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_m ^ w_cout;
`else
    assign w_m        = 1'b0;
    assign w_do_add   = r_q[0];
    assign w_add_sign = w_cout;
`endif

    addsub_slice #(
        .WIDTH (WIDTH)
    ) u_slice (
        .A    (r_a),
        .B    (r_b),
        .M    (w_m),
        .S    (w_s),
        .Cout (w_cout)
    );

    always_comb begin
        w_state_next   = r_state;
        w_a_next       = r_a;
        w_q_next       = r_q;
        w_b_next       = r_b;
        w_c_next       = r_c;
        w_p_next       = r_p;
        w_product_next = r_product;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        w_qm1_next     = r_qm1;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_ADD;
                    w_b_next     = multiplicand;
                    w_q_next     = multiplier;
                    w_a_next     = '0;
                    w_c_next     = 1'b0;
                    w_p_next     = CNT_W'(WIDTH);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
                    w_qm1_next   = 1'b0;
`endif
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (w_do_add) begin
                    w_a_next = w_s;
                    w_c_next = w_add_sign;
                end
`ifdef SHIFT_ADD_MULT_SIGNED_EN
                else begin
                    w_c_next = r_a[WIDTH-1];
                end
`endif
                w_p_next     = r_p - CNT_W'(1);
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                // C feeds A's top bit: the add carry (unsigned) or the sign (Booth).
                w_a_next = {r_c, r_a[WIDTH-1:1]};
                w_q_next = {r_a[0], r_q[WIDTH-1:1]};
`ifdef SHIFT_ADD_MULT_SIGNED_EN
                w_qm1_next = r_q[0];
`else
                w_c_next   = 1'b0;
`endif
                if (r_p == '0) begin
                    w_state_next   = ST_DONE;
                    w_product_next = {w_a_next, w_q_next};
                end else begin
                    w_state_next = ST_ADD;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_b       <= '0;
            r_c       <= 1'b0;
            r_p       <= '0;
            r_product <= '0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
            r_qm1     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_a       <= w_a_next;
            r_q       <= w_q_next;
            r_b       <= w_b_next;
            r_c       <= w_c_next;
            r_p       <= w_p_next;
            r_product <= w_product_next;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
            r_qm1     <= w_qm1_next;
`endif
        end
    end

    assign product = r_product;
    assign busy    = (r_state == ST_ADD) || (r_state == ST_SHIFT);
    assign done    = (r_state == ST_DONE);

endmodule
